pipe_stage_ctrl: RTL and testbench

- Parametrised N-stage in-order pipeline sequencer. Generalises the fixed five-stage FE/DE/AGEX/MEM/WB frame and its free-running cycle counter.
- Holds a DATA_W payload plus a valid bit per stage. Applies per-stage stall requests and a targeted flush.
- Exposes retire output and performance counters (cycles, retired, stall cycles).
- Sits under the core top; stage datapaths attach to stage_data/stage_valid.

---
 rtl/pipe_stage_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_ctrl.sv
// N-stage in-order pipeline sequencer: per-stage valid/payload, stall holds, targeted flush, perf counters.
// Build option: define PIPE_CTRL_CNT_SAT_EN to make the counters saturate instead of wrap.
module pipe_stage_ctrl #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned SEL_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic [NUM_STAGES-1:0]        stall_req,
  input  logic                         flush_req,
  input  logic [SEL_W-1:0]             flush_stage,
  output logic [NUM_STAGES-1:0]        stage_valid,
  output logic [NUM_STAGES*DATA_W-1:0] stage_data,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [CNT_W-1:0]             cycle_count,
  output logic [CNT_W-1:0]             retire_count,
  output logic [CNT_W-1:0]             stall_count
);

  localparam int unsigned LAST = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_d;
  logic [DATA_W-1:0]     data_q [NUM_STAGES];
  logic [DATA_W-1:0]     data_d [NUM_STAGES];

  logic [NUM_STAGES-1:0] kill;
  logic [NUM_STAGES-1:0] eff_stall;
  logic [NUM_STAGES-1:0] hold;
  logic                  accept;
  logic                  retire;
  logic                  any_stall;

  logic [CNT_W-1:0]      cycle_q;
  logic [CNT_W-1:0]      retire_q;
  logic [CNT_W-1:0]      stall_q;

  // Counter step: wraps by default, sticks at all-ones when saturation is built in.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef PIPE_CTRL_CNT_SAT_EN
    bump = (&c) ? c : c + CNT_W'(1);
`else
    bump = c + CNT_W'(1);
`endif
  endfunction

  // Kill mask, effective stalls and the hold cascade toward younger stages.
  always_comb begin
    kill      = '0;
    eff_stall = '0;
    hold      = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      kill[i] = flush_req && (32'(flush_stage) > 32'(i));
    end
    eff_stall = stall_req & valid_q & ~kill;
    for (int i = 0; i < NUM_STAGES; i++) begin
      hold[i] = |(eff_stall >> i);
    end
  end

  assign in_ready  = ~reset & ~hold[0] & ~flush_req;
  assign accept    = in_valid & in_ready;
  assign any_stall = |eff_stall;
  assign retire    = valid_q[LAST] & ~hold[LAST] & ~kill[LAST];

  // Per-stage advance: kill beats hold beats bubble beats shift-in.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (kill[0]) begin
      valid_d[0] = 1'b0;
    end else if (!hold[0]) begin
      valid_d[0] = accept;
      if (accept) begin
        data_d[0] = in_data;
      end
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (kill[i]) begin
        valid_d[i] = 1'b0;
      end else if (!hold[i]) begin
        if (hold[i-1]) begin
          valid_d[i] = 1'b0;
        end else begin
          // A killed producer hands over nothing, even though it is not held.
          valid_d[i] = valid_q[i-1] & ~kill[i-1];
          data_d[i]  = data_q[i-1];
        end
      end
    end
  end

  // Stage state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q  <= '0;
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      cycle_q <= bump(cycle_q);
      if (retire) begin
        retire_q <= bump(retire_q);
      end
      if (any_stall) begin
        stall_q <= bump(stall_q);
      end
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_flat
    assign stage_data[g*DATA_W +: DATA_W] = data_q[g];
  end

  assign stage_valid  = valid_q;
  assign out_valid    = valid_q[LAST];
  assign out_data     = data_q[LAST];
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl: streaming, stalls, flushes, reset and counter width behaviour.
module tb_pipe_stage_ctrl;

  localparam int unsigned N  = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;
  localparam int unsigned SW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready;
  logic [N-1:0]    stall_req = '0;
  logic            flush_req = 1'b0;
  logic [SW-1:0]   flush_stage = '0;
  logic [N-1:0]    stage_valid;
  logic [N*DW-1:0] stage_data;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   cycle_count, retire_count, stall_count;

  logic            sm_reset = 1'b1;
  logic            sm_in_ready;
  logic [N-1:0]    sm_stage_valid;
  logic [N*8-1:0]  sm_stage_data;
  logic            sm_out_valid;
  logic [7:0]      sm_out_data;
  logic [3:0]      sm_cycle, sm_retire, sm_stall;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_ctrl #(.NUM_STAGES(N), .DATA_W(DW), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall_req(stall_req), .flush_req(flush_req), .flush_stage(flush_stage),
    .stage_valid(stage_valid), .stage_data(stage_data), .out_valid(out_valid), .out_data(out_data),
    .cycle_count(cycle_count), .retire_count(retire_count), .stall_count(stall_count)
  );

  pipe_stage_ctrl #(.NUM_STAGES(N), .DATA_W(8), .CNT_W(4)) u_small (
    .clk(clk), .reset(sm_reset), .in_valid(1'b0), .in_data(8'h00), .in_ready(sm_in_ready),
    .stall_req(5'b00000), .flush_req(1'b0), .flush_stage(3'd0),
    .stage_valid(sm_stage_valid), .stage_data(sm_stage_data), .out_valid(sm_out_valid),
    .out_data(sm_out_data), .cycle_count(sm_cycle), .retire_count(sm_retire), .stall_count(sm_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [N-1:0] st,
                       input logic fr, input logic [SW-1:0] fs);
    in_valid    = v;
    in_data     = d;
    stall_req   = st;
    flush_req   = fr;
    flush_stage = fs;
    #1;
  endtask

  function automatic logic [DW-1:0] sd(input int i);
    return stage_data[i*DW +: DW];
  endfunction

  initial begin
    // Reset state, with an offer pending to show in_ready stays low.
    drive(1'b1, 32'h99, '0, 1'b0, '0);
    repeat (2) step();
    check("rst_valid", stage_valid, 0);
    check("rst_data", stage_data, 0);
    check("rst_ready", in_ready, 0);
    check("rst_cycle", cycle_count, 0);
    check("rst_retire", retire_count, 0);
    check("rst_stall", stall_count, 0);
    drive(1'b0, '0, '0, 1'b0, '0);
    reset = 1'b0;

    // Stream 0x11, 0x22, 0x33 back-to-back.
    drive(1'b1, 32'h11, '0, 1'b0, '0);
    check("t1_ready", in_ready, 1);
    step();
    drive(1'b1, 32'h22, '0, 1'b0, '0);
    step();
    drive(1'b1, 32'h33, '0, 1'b0, '0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0);
    step();
    step();
    check("t1_out_valid5", out_valid, 1);
    check("t1_out_data5", out_data, 32'h11);
    check("t1_cycle5", cycle_count, 5);
    check("t1_retire5", retire_count, 0);
    step();
    check("t1_out_data6", out_data, 32'h22);
    check("t1_retire6", retire_count, 1);
    step();
    check("t1_out_data7", out_data, 32'h33);
    check("t1_retire7", retire_count, 2);
    step();
    check("t1_out_valid8", out_valid, 0);
    check("t1_retire8", retire_count, 3);
    check("t1_stall8", stall_count, 0);
    check("t1_cycle8", cycle_count, 8);

    // Stall stage 2 for two cycles while 0x54 is offered.
    drive(1'b1, 32'h51, '0, 1'b0, '0);
    step();
    drive(1'b1, 32'h52, '0, 1'b0, '0);
    step();
    drive(1'b1, 32'h53, '0, 1'b0, '0);
    step();
    drive(1'b1, 32'h54, 5'b00100, 1'b0, '0);
    check("t2_ready_s1", in_ready, 0);
    step();
    check("t2_valid_s1", stage_valid, 5'b00111);
    check("t2_s2_data_s1", sd(2), 32'h51);
    check("t2_stall_s1", stall_count, 1);
    check("t2_ready_s2", in_ready, 0);
    step();
    check("t2_valid_s2", stage_valid, 5'b00111);
    check("t2_s0_data_s2", sd(0), 32'h53);
    check("t2_stall_s2", stall_count, 2);
    drive(1'b1, 32'h54, '0, 1'b0, '0);
    check("t2_ready_go", in_ready, 1);
    step();
    drive(1'b0, '0, '0, 1'b0, '0);
    check("t2_valid_go", stage_valid, 5'b01111);
    step();
    check("t2_out_a", out_data, 32'h51);
    step();
    check("t2_out_b", out_data, 32'h52);
    step();
    check("t2_out_c", out_data, 32'h53);
    step();
    check("t2_out_d", out_data, 32'h54);
    step();
    check("t2_retire", retire_count, 7);
    check("t2_empty", stage_valid, 0);
    check("t2_stall_end", stall_count, 2);

    // Fill with 0xA4 oldest .. 0xA0 youngest, then flush stages 0..1.
    for (int k = 4; k >= 0; k--) begin
      drive(1'b1, 32'hA0 + 32'(k), '0, 1'b0, '0);
      step();
    end
    check("t3_full", stage_valid, 5'b11111);
    check("t3_s4", out_data, 32'hA4);
    check("t3_retire_pre", retire_count, 7);
    drive(1'b1, 32'hEE, '0, 1'b1, 3'd2);
    check("t3_ready_flush", in_ready, 0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0);
    check("t3_valid_post", stage_valid, 5'b11000);
    check("t3_out_post", out_data, 32'hA3);
    check("t3_s3_post", sd(3), 32'hA2);
    check("t3_retire_post", retire_count, 8);
    step();
    step();
    check("t3_empty", stage_valid, 0);
    check("t3_retire_end", retire_count, 10);

    // Flush stage_2 with a stall request on killed stage 1.
    drive(1'b1, 32'hB0, '0, 1'b0, '0);
    step();
    drive(1'b1, 32'hB1, '0, 1'b0, '0);
    step();
    drive(1'b0, '0, 5'b00010, 1'b1, 3'd2);
    check("t4_ready", in_ready, 0);
    step();
    check("t4_valid", stage_valid, 0);
    check("t4_stall", stall_count, 2);

    // Flush below stage 2 while stage 2 stalls: stall wins at stage 2.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hC0 + 32'(k), '0, 1'b0, '0);
      step();
    end
    drive(1'b0, '0, 5'b00100, 1'b1, 3'd2);
    step();
    check("t4b_valid", stage_valid, 5'b00100);
    check("t4b_s2", sd(2), 32'hC0);
    check("t4b_stall", stall_count, 3);
    drive(1'b1, 32'hD0, '0, 1'b0, '0);
    step();
    drive(1'b1, 32'hD1, '0, 1'b0, '0);
    step();
    check("t5_pre", stage_valid, 5'b10011);
    check("t5_out_pre", out_data, 32'hC0);

    // Flush everything with a stall on the retiring stage.
    drive(1'b0, '0, 5'b10000, 1'b1, 3'd5);
    step();
    drive(1'b0, '0, '0, 1'b0, '0);
    check("t5_valid", stage_valid, 0);
    check("t5_retire", retire_count, 10);
    check("t5_stall", stall_count, 3);

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hE0 + 32'(k), '0, 1'b0, '0);
      step();
    end
    check("t7_inflight", stage_valid, 5'b00111);
    #2;
    reset = 1'b1;
    #1;
    check("t7_valid", stage_valid, 0);
    check("t7_cycle", cycle_count, 0);
    check("t7_retire", retire_count, 0);
    check("t7_stall", stall_count, 0);
    check("t7_ready", in_ready, 0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0);
    reset = 1'b0;
    drive(1'b1, 32'hF0, '0, 1'b0, '0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0);
    repeat (3) step();
    check("t7_out_early", out_valid, 0);
    step();
    check("t7_out_valid", out_valid, 1);
    check("t7_out_data", out_data, 32'hF0);
    check("t7_retire_pre", retire_count, 0);
    step();
    check("t7_retire_post", retire_count, 1);
    check("t7_cycle_post", cycle_count, 6);

    // Narrow counter: 20 free-running edges.
    check("t6_rst", sm_cycle, 0);
    sm_reset = 1'b0;
    repeat (20) step();
`ifdef PIPE_CTRL_CNT_SAT_EN
    check("t6_cycle", sm_cycle, 15);
`else
    check("t6_cycle", sm_cycle, 4);
`endif
    check("t6_retire", sm_retire, 0);
    check("t6_stall", sm_stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
